// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map offsets,
// gateway state encoding and the claim-ID width helper.
package intc_pkg;

  // PRIORITY[k] sits at PRIO_BASE + k; the remaining offsets are added to N.
  localparam int PRIO_BASE     = 0;
  localparam int PENDING_OFS   = 0;
  localparam int ENABLE_OFS    = 1;
  localparam int THRESHOLD_OFS = 2;
  localparam int CLAIM_OFS     = 3;

  typedef enum logic [1:0] {
    GW_IDLE       = 2'd0,
    GW_PENDING    = 2'd1,
    GW_IN_SERVICE = 2'd2
  } gw_state_t;

  function automatic int id_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/priority_search_tree.sv
// Combinational max-priority search over N masked sources; zero latency, no backpressure.
// Equal priorities resolve to the lower source index.
module priority_search_tree #(
  parameter  int W = 3,
  parameter  int N = 8,
  localparam int L = $clog2(N)
) (
  input  logic [N-1:0][W-1:0] prio,
  input  logic [N-1:0]        mask,
  output logic                valid,
  output logic [L-1:0]        index,
  output logic [W-1:0]        max_prio
);

  // Heap layout: node n has children 2n+1 (lower indices) and 2n+2; leaves at N-1+k.
  logic [W-1:0] node_prio [2*N-1];
  logic         node_vld  [2*N-1];
  logic [L-1:0] node_idx  [2*N-1];

  always_comb begin
    logic take_left;
    take_left = 1'b0;
    node_prio = '{default: '0};
    node_vld  = '{default: 1'b0};
    node_idx  = '{default: '0};
    for (int k = 0; k < N; k++) begin
      node_prio[N-1+k] = prio[k];
      node_vld[N-1+k]  = mask[k];
      node_idx[N-1+k]  = L'(k);
    end
    for (int n = N - 2; n >= 0; n--) begin
      take_left = node_vld[2*n+1] &&
                  (!node_vld[2*n+2] || (node_prio[2*n+1] >= node_prio[2*n+2]));
      node_vld[n]  = node_vld[2*n+1] | node_vld[2*n+2];
      node_prio[n] = take_left ? node_prio[2*n+1] : node_prio[2*n+2];
      node_idx[n]  = take_left ? node_idx[2*n+1]  : node_idx[2*n+2];
    end
  end

  assign valid    = node_vld[0];
  assign index    = node_idx[0];
  assign max_prio = node_prio[0];

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller with claim/complete register port; 1-cycle read latency, o_irq registered, no backpressure.
// Define INTC_EDGE_TRIGGER_EN for rising-edge sources; level-sensitive otherwise.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter  int W = 3,
  parameter  int N = 8,
  localparam int A = $clog2(N + 4),
  localparam int I = id_width(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_sources,
  input  logic         i_rd_en,
  input  logic         i_wr_en,
  input  logic [A-1:0] i_addr,
  input  logic [31:0]  i_wdata,
  output logic [31:0]  o_rdata,
  output logic         o_rdata_valid,
  output logic         o_irq
);

  localparam int L = $clog2(N);
  localparam logic [A-1:0] ADDR_PRIO_END  = A'(PRIO_BASE + N);
  localparam logic [A-1:0] ADDR_PENDING   = A'(N + PENDING_OFS);
  localparam logic [A-1:0] ADDR_ENABLE    = A'(N + ENABLE_OFS);
  localparam logic [A-1:0] ADDR_THRESHOLD = A'(N + THRESHOLD_OFS);
  localparam logic [A-1:0] ADDR_CLAIM     = A'(N + CLAIM_OFS);

  logic [N-1:0][W-1:0] prio;
  logic [N-1:0]        enable;
  logic [W-1:0]        threshold;

  gw_state_t           gw_state [N];
  gw_state_t           gw_next  [N];
  logic [N-1:0]        pending;
  logic [N-1:0]        in_service;
  logic [N-1:0]        active;
  logic [N-1:0]        eligible;

  logic                tree_vld;
  logic [L-1:0]        tree_idx;
  logic [W-1:0]        tree_prio;
  logic                qualified;
  logic [I-1:0]        claim_id;

  logic                claim;
  logic                cmp_in_range;
  logic [L-1:0]        cmp_idx;
  logic                complete;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^i_wdata;

`ifdef INTC_EDGE_TRIGGER_EN
  logic [N-1:0] src_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) src_prev <= '0;
    else       src_prev <= i_sources;
  end

  assign active = i_sources & ~src_prev;
`else
  assign active = i_sources;
`endif

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N; k++)
      eligible[k] = pending[k] & enable[k] & (prio[k] != '0);
  end

  priority_search_tree #(
    .W (W),
    .N (N)
  ) u_tree (
    .prio     (prio),
    .mask     (eligible),
    .valid    (tree_vld),
    .index    (tree_idx),
    .max_prio (tree_prio)
  );

  assign qualified = tree_vld && (tree_prio > threshold);
  assign claim_id  = qualified ? (I'(tree_idx) + I'(1)) : '0;

  assign claim        = i_rd_en && (i_addr == ADDR_CLAIM) && qualified;
  assign cmp_in_range = (i_wdata != 32'd0) && (i_wdata <= 32'(N));
  assign cmp_idx      = L'(i_wdata - 32'd1);
  assign complete     = i_wr_en && (i_addr == ADDR_CLAIM) && cmp_in_range && in_service[cmp_idx];

  // Gateway FSM per source: state register, next state, decoded outputs.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N; k++) begin
      if (i_rst) gw_state[k] <= GW_IDLE;
      else       gw_state[k] <= gw_next[k];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      gw_next[k] = gw_state[k];
      case (gw_state[k])
        GW_IDLE:       if (active[k]) gw_next[k] = GW_PENDING;
        GW_PENDING:    if (claim && (tree_idx == L'(k))) gw_next[k] = GW_IN_SERVICE;
        GW_IN_SERVICE: if (complete && (cmp_idx == L'(k))) gw_next[k] = GW_IDLE;
        default:       gw_next[k] = GW_IDLE;
      endcase
    end
  end

  always_comb begin
    pending    = '0;
    in_service = '0;
    for (int k = 0; k < N; k++) begin
      pending[k]    = (gw_state[k] == GW_PENDING);
      in_service[k] = (gw_state[k] == GW_IN_SERVICE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio      <= '0;
      enable    <= '0;
      threshold <= '0;
    end else if (i_wr_en) begin
      if (i_addr < ADDR_PRIO_END)           prio[i_addr[L-1:0]] <= i_wdata[W-1:0];
      else if (i_addr == ADDR_ENABLE)       enable              <= i_wdata[N-1:0];
      else if (i_addr == ADDR_THRESHOLD)    threshold           <= i_wdata[W-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (i_addr < ADDR_PRIO_END)           rd_mux = 32'(prio[i_addr[L-1:0]]);
    else if (i_addr == ADDR_PENDING)      rd_mux = 32'(pending);
    else if (i_addr == ADDR_ENABLE)       rd_mux = 32'(enable);
    else if (i_addr == ADDR_THRESHOLD)    rd_mux = 32'(threshold);
    else if (i_addr == ADDR_CLAIM)        rd_mux = 32'(claim_id);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_irq         <= 1'b0;
    end else begin
      o_rdata_valid <= i_rd_en;
      if (i_rd_en) o_rdata <= rd_mux;
      o_irq <= qualified;
    end
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Platform-level interrupt controller for the core: latches up to N external interrupt sources, holds per-source priority and enable configuration plus a global threshold, and raises one registered interrupt line to the hart. The core services interrupts through a claim/complete register pair on a simple word-addressed register port. A combinational priority search tree selects the winning source each cycle.

## Interface
- W, 3: priority field width in bits; 1 ≤ W ≤ 32.
- N, 8: number of interrupt sources; power of 2, 2 ≤ N ≤ 32.
- A, $clog2(N+4) (derived): register word-address width.
- I, $clog2(N+1) (derived): claim ID width.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_sources  in  N  interrupt request lines, already synchronised to i_clk.
- i_rd_en  in  1  register read strobe, one cycle.
- i_wr_en  in  1  register write strobe, one cycle.
- i_addr  in  A  word address.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, valid when o_rdata_valid is high.
- o_rdata_valid  out  1  read response strobe.
- o_irq  out  1  external interrupt request to the core.

## Operation
- Register map (word addresses): k in 0..N-1 = PRIORITY[k] (RW, bits W-1:0, rest read 0); N = PENDING (RO, bit k = pending[k]); N+1 = ENABLE (RW, bits N-1:0); N+2 = THRESHOLD (RW, bits W-1:0); N+3 = CLAIM/COMPLETE. Unmapped reads return 0; unmapped or RO writes are ignored.
- Per-source gateway states: IDLE, PENDING, IN_SERVICE.
  - IDLE -> PENDING when the source is active (see Configuration).
  - PENDING -> IN_SERVICE when claimed.
  - IN_SERVICE -> IDLE on complete with matching ID.
  - Activity while PENDING or IN_SERVICE is dropped; it is not counted.
- Eligible[k] = pending[k] & enable[k] & (priority[k] != 0). The tree input is the priority vector with eligible as the pending mask. Ties resolve to the lower index.
- Winner qualifies when the tree output is valid and priority[winner] > THRESHOLD (strict).
- CLAIM read returns ID = winner+1 when a winner qualifies, else 0.
  - A nonzero claim moves that source to IN_SERVICE in the same edge that captures the read.
- COMPLETE write with ID in 1..N whose source is IN_SERVICE returns it to IDLE. Any other ID is ignored.
- Disabling a PENDING source keeps it pending; it only stops being eligible.

## Timing
- Reset values:
  - PRIORITY, ENABLE, THRESHOLD, pending, in-service: all 0.
  - Edge-detect history: 0.
  - o_irq, o_rdata, o_rdata_valid: 0.
- Read latency is 1 cycle: o_rdata and o_rdata_valid are registered and follow i_rd_en by one edge. o_rdata_valid is high for exactly one cycle.
- Simultaneous i_rd_en and i_wr_en:
  - Both act.
  - The read returns pre-write register contents.
  - A claim uses pre-edge state.
  - A complete and a claim in the same cycle are both applied.
- o_irq is registered from qualified-winner-exists, so it trails any pending, enable, priority, threshold or claim change by exactly 1 cycle.
- A source activating at edge t is visible in PENDING and at the tree at t+1, and on o_irq at t+2.
- Reset asserted mid-operation clears all state on the next edge. A read issued in the reset cycle returns no response.

## Configuration
- INTC_EDGE_TRIGGER_EN defined:
  - A source is active on a rising edge of i_sources[k] (current 1, previous sampled 0).
  - A line already high when reset is released registers one edge.
- Undefined:
  - Level-sensitive: a source is active whenever i_sources[k] is 1.
  - A line still high after complete re-enters PENDING on the next edge.

## Structure
- Package intc_pkg holds:
  - register offset constants relative to N (PRIO_BASE, PENDING_OFS, ENABLE_OFS, THRESHOLD_OFS, CLAIM_OFS);
  - the gateway state enum type;
  - the ID-width helper function.
- One sub-module: priority_search_tree, instantiated with W and N, driven by the priority array and the eligible mask.
- The gateway state, register file and read mux are local to interrupt_controller.

## Test plan
- Reset, then read all addresses -> every read returns 0, o_irq = 0, o_rdata_valid pulses 1 cycle after each i_rd_en.
- PRIORITY[3]=5, ENABLE=0x08, THRESHOLD=0, pulse source 3 -> o_irq high 2 cycles after the source edge; CLAIM returns 4; o_irq low 1 cycle after claim; COMPLETE 4 -> gateway returns to IDLE.
- PRIORITY[2]=4, PRIORITY[5]=4, PRIORITY[6]=6, all enabled and pending -> claims return 7, 3, 6 in order.
- THRESHOLD=6 with max eligible priority 6 -> o_irq stays 0 and CLAIM returns 0; set THRESHOLD=5 -> o_irq rises 1 cycle later.
- Level mode, source 1 held high, claim then COMPLETE 2 -> source re-pends and o_irq re-asserts. Edge mode with the same stimulus -> no re-pend.
- COMPLETE 9 with N=8, and COMPLETE for a non-in-service ID -> no state change. Claim and complete issued in the same cycle -> both take effect.
